// File: rtl/fht_stream_io.sv
// fht_stream_io: streaming front/back end for the FHT core.
// Loads a frame of ADC samples into the banked core RAM, starts the core,
// waits for it to finish, then streams the result out in natural order.
//
// Handshakes: every stream moves one item on a cycle where its valid and
// ready are both high at the rising clock edge. A source holds valid and
// data stable until that edge. Ready may change freely and never depends
// combinationally on valid. The sample input is iVALID/oREADY and the result
// output is oVALID/iREADY.
//
// State encoding on dbg_state: 0 LOAD, 1 KICK, 2 RUN, 3 UNLOAD.
module fht_stream_io #(
    parameter int N_BANK   = 4,
    parameter int B_BIT    = 2,
    parameter int A_BIT    = 8,
    parameter int ADC_BIT  = 14,
    parameter int D_BIT    = 18,
    parameter int SIGN_EXT = 1
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iVALID,
    input  logic [ADC_BIT-1:0]      iDATA,
    output logic                    oREADY,
    output logic [N_BANK-1:0]       oCORE_WE,
    output logic [D_BIT-1:0]        oCORE_DATA,
    output logic [A_BIT-1:0]        oCORE_ADDR_WR,
    output logic                    oCORE_START,
    input  logic                    iCORE_RDY,
    output logic [N_BANK*A_BIT-1:0] oCORE_ADDR_RD,
    input  logic [N_BANK*D_BIT-1:0] iCORE_DATA,
    output logic                    oVALID,
    output logic [D_BIT-1:0]        oDATA,
    output logic                    oLAST,
    input  logic                    iREADY,
    output logic                    oBUSY,
    output logic [1:0]              dbg_state
);

    // Frame index width: low B_BIT bits pick the bank, the rest is the address.
    localparam int C_BIT = B_BIT + A_BIT;
    // Frame size is a power of two, so the last index is all ones.
    localparam logic [C_BIT-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_KICK   = 2'd1,
        ST_RUN    = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Load side
    logic               ready_q;
    logic [C_BIT-1:0]   wr_cnt;
    logic [N_BANK-1:0]  we_q;
    logic [N_BANK-1:0]  we_hot;
    logic [A_BIT-1:0]   waddr_q;
    logic [D_BIT-1:0]   wdata_q;
    logic [D_BIT-1:0]   ext_data;
    logic               accept;
    logic               last_wr;

    // Core handshake
    logic               start_q;
    logic               seen_low;

    // Unload side: rd_idx has one extra bit so it can park at N without wrapping
    logic [C_BIT:0]     rd_idx;
    logic               rd_pend;
    logic [B_BIT-1:0]   rd_lane;
    logic [D_BIT-1:0]   lane_data;
    logic [C_BIT-1:0]   out_idx;
    logic [D_BIT-1:0]   fifo_mem [2];
    logic               fifo_wptr;
    logic               fifo_rptr;
    logic [1:0]         fifo_cnt;
    logic [1:0]         cnt_after_pop;
    logic               issue;
    logic               pop;
    logic               last_pop;

    assign accept  = (state == ST_LOAD) && iVALID && ready_q;
    assign last_wr = (wr_cnt == LAST_IDX);

    // Widen the raw sample to the core width, replicating the sign bit or padding with zeros.
    always_comb begin
        ext_data = '0;
        ext_data[ADC_BIT-1:0] = iDATA;
        for (int i = ADC_BIT; i < D_BIT; i++) begin
            ext_data[i] = (SIGN_EXT != 0) ? iDATA[ADC_BIT-1] : 1'b0;
        end
    end

    // One-hot bank enable for the sample about to be written.
    always_comb begin
        we_hot = '0;
        for (int k = 0; k < N_BANK; k++) begin
            we_hot[k] = (wr_cnt[B_BIT-1:0] == B_BIT'(k));
        end
    end

    // Pick the bank lane that was addressed on the previous cycle.
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < N_BANK; k++) begin
            if (rd_lane == B_BIT'(k)) begin
                lane_data = iCORE_DATA[k*D_BIT +: D_BIT];
            end
        end
    end

    // Next state plus unload flow control. A read is issued only when the
    // FIFO has room for it counting the entry leaving this cycle, which keeps
    // one point per cycle flowing while never exceeding two entries.
    always_comb begin
        next_state    = state;
        pop           = 1'b0;
        last_pop      = 1'b0;
        issue         = 1'b0;
        cnt_after_pop = fifo_cnt;
        case (state)
            ST_LOAD: begin
                if (accept && last_wr) begin
                    next_state = ST_KICK;
                end
            end
            ST_KICK: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                // Only a 0-then-1 transition seen inside RUN means the core finished.
                if (seen_low && iCORE_RDY) begin
                    next_state = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                pop           = oVALID && iREADY;
                last_pop      = pop && (out_idx == LAST_IDX);
                cnt_after_pop = fifo_cnt - {1'b0, pop};
                issue         = !rd_idx[C_BIT] &&
                                ((cnt_after_pop + {1'b0, rd_pend}) < 2'd2);
                if (last_pop) begin
                    next_state = ST_LOAD;
                end
            end
            default: begin
                next_state = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Input ready is registered: high on every cycle the FSM sits in LOAD.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (next_state == ST_LOAD);
        end
    end

    // Scatter each accepted sample to its bank one cycle after acceptance.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            wr_cnt  <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= '0;
            if (accept) begin
                we_q    <= we_hot;
                waddr_q <= wr_cnt[C_BIT-1:B_BIT];
                wdata_q <= ext_data;
                wr_cnt  <= last_wr ? '0 : wr_cnt + C_BIT'(1);
            end
        end
    end

    // Start strobe during the single RUN entry cycle; track a low RDY inside RUN.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            start_q  <= 1'b0;
            seen_low <= 1'b0;
        end else begin
            start_q  <= (state == ST_KICK);
            seen_low <= (state == ST_RUN) && (seen_low || !iCORE_RDY);
        end
    end

    // Read issue counter and the one-cycle in-flight marker for the core read.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_idx  <= '0;
            rd_pend <= 1'b0;
            rd_lane <= '0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                rd_lane <= rd_idx[B_BIT-1:0];
            end
            if (last_pop) begin
                rd_idx <= '0;
            end else if (issue) begin
                rd_idx <= rd_idx + (C_BIT+1)'(1);
            end
        end
    end

    // Two-entry output FIFO: returning read data goes in, handshakes take it out.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wptr   <= 1'b0;
            fifo_rptr   <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (rd_pend) begin
                fifo_mem[fifo_wptr] <= lane_data;
                fifo_wptr           <= ~fifo_wptr;
            end
            if (pop) begin
                fifo_rptr <= ~fifo_rptr;
            end
            case ({rd_pend, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Output point counter, used to flag the last point of the frame.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            out_idx <= '0;
        end else if (pop) begin
            out_idx <= last_pop ? '0 : out_idx + C_BIT'(1);
        end
    end

    assign oREADY        = ready_q;
    assign oCORE_WE      = we_q;
    assign oCORE_DATA    = wdata_q;
    assign oCORE_ADDR_WR = waddr_q;
    assign oCORE_START   = start_q;
    assign oCORE_ADDR_RD = {N_BANK{rd_idx[C_BIT-1:B_BIT]}};
    assign oVALID        = (fifo_cnt != 2'd0);
    assign oDATA         = fifo_mem[fifo_rptr];
    assign oLAST         = oVALID && (out_idx == LAST_IDX);
    assign oBUSY         = (state != ST_LOAD);
    assign dbg_state     = state;

endmodule

// File: tb/tb_fht_stream_io.sv
// Bench for fht_stream_io: a 4-bank sign-extending instance (N=16) and an
// 8-bank zero-extending instance (N=64), each with a banked RAM core model.
`timescale 1ns/1ps
module tb_fht_stream_io;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_UNLOAD = 2'd3;

  logic clk;
  logic rst_n;

  // Instance A: N_BANK=4, A_BIT=2, sign extension
  logic        a_valid, a_ready, a_start, a_crdy, a_ovalid, a_olast, a_busy;
  logic        a_iready = 1'b1;
  logic [13:0] a_data;
  logic [3:0]  a_we;
  logic [17:0] a_cdata, a_odata;
  logic [1:0]  a_waddr, a_state;
  logic [7:0]  a_raddr;
  logic [71:0] a_rdata;

  // Instance B: N_BANK=8, A_BIT=3, zero extension
  logic         b_valid, b_ready, b_start, b_crdy, b_ovalid, b_olast, b_busy;
  logic         b_iready = 1'b1;
  logic [13:0]  b_data;
  logic [7:0]   b_we;
  logic [17:0]  b_cdata, b_odata;
  logic [2:0]   b_waddr;
  logic [1:0]   b_state;
  logic [23:0]  b_raddr;
  logic [143:0] b_rdata;

  // Scoreboard state
  logic [17:0] exp_a[$];
  logic [17:0] exp_b[$];
  int          checks = 0;
  int          errors = 0;
  int          out_cnt_a = 0, out_cnt_b = 0;
  int          lasts_a = 0, lasts_b = 0;
  bit          rmode = 1'b0;
  logic [17:0] ofs_a = '0;
  logic [13:0] smp [64];
  logic [17:0] mem_a [4][4];
  logic [17:0] mem_b [8][8];

  fht_stream_io #(.N_BANK(4), .B_BIT(2), .A_BIT(2), .ADC_BIT(14), .D_BIT(18), .SIGN_EXT(1)) dut_a (
    .iCLK(clk), .iRESET(rst_n), .iVALID(a_valid), .iDATA(a_data), .oREADY(a_ready),
    .oCORE_WE(a_we), .oCORE_DATA(a_cdata), .oCORE_ADDR_WR(a_waddr), .oCORE_START(a_start),
    .iCORE_RDY(a_crdy), .oCORE_ADDR_RD(a_raddr), .iCORE_DATA(a_rdata), .oVALID(a_ovalid),
    .oDATA(a_odata), .oLAST(a_olast), .iREADY(a_iready), .oBUSY(a_busy), .dbg_state(a_state)
  );

  fht_stream_io #(.N_BANK(8), .B_BIT(3), .A_BIT(3), .ADC_BIT(14), .D_BIT(18), .SIGN_EXT(0)) dut_b (
    .iCLK(clk), .iRESET(rst_n), .iVALID(b_valid), .iDATA(b_data), .oREADY(b_ready),
    .oCORE_WE(b_we), .oCORE_DATA(b_cdata), .oCORE_ADDR_WR(b_waddr), .oCORE_START(b_start),
    .iCORE_RDY(b_crdy), .oCORE_ADDR_RD(b_raddr), .iCORE_DATA(b_rdata), .oVALID(b_ovalid),
    .oDATA(b_odata), .oLAST(b_olast), .iREADY(b_iready), .oBUSY(b_busy), .dbg_state(b_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- core models ----------------
  // Banked RAM with one-cycle registered read; instance A adds ofs_a on read.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (a_we[k]) mem_a[k][a_waddr] <= a_cdata;
      a_rdata[k*18 +: 18] <= mem_a[k][a_raddr[k*2 +: 2]] + ofs_a;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (b_we[k]) mem_b[k][b_waddr] <= b_cdata;
      b_rdata[k*18 +: 18] <= mem_b[k][b_raddr[k*3 +: 3]];
    end
  end

  // Core RDY: stays high into RUN, drops for 3 cycles, then rises.
  initial begin
    a_crdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && a_start) begin
        repeat (2) @(negedge clk);
        chk("a_rdy_level_ignored", a_state, ST_RUN);
        a_crdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_rdy_wait_edge", a_state, ST_RUN);
        a_crdy = 1'b1;
      end
    end
  end

  initial begin
    b_crdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && b_start) begin
        repeat (2) @(negedge clk);
        chk("b_rdy_level_ignored", b_state, ST_RUN);
        b_crdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("b_rdy_wait_edge", b_state, ST_RUN);
        b_crdy = 1'b1;
      end
    end
  end

  // Downstream ready: continuous or 50% random, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      a_iready = rmode ? 1'($urandom_range(1)) : 1'b1;
      b_iready = rmode ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // ---------------- output monitors ----------------
  initial begin
    logic [17:0] hold, e;
    bit stall;
    stall = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_cnt_a = 0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("a_stall_valid", a_ovalid, 1);
          chk("a_stall_data", a_odata, hold);
        end
        if (a_ovalid && a_iready) begin
          if (exp_a.size() == 0) chk("a_extra_point", 64'(exp_a.size()), 64'd1);
          else begin
            e = exp_a.pop_front();
            chk("a_data", a_odata, e);
          end
          chk("a_last", a_olast, (out_cnt_a == 15));
          if (out_cnt_a == 15) begin out_cnt_a = 0; lasts_a++; end
          else out_cnt_a++;
        end
        stall = a_ovalid && !a_iready;
        hold = a_odata;
      end
    end
  end

  initial begin
    logic [17:0] hold, e;
    bit stall;
    stall = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_cnt_b = 0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("b_stall_valid", b_ovalid, 1);
          chk("b_stall_data", b_odata, hold);
        end
        if (b_ovalid && b_iready) begin
          if (exp_b.size() == 0) chk("b_extra_point", 64'(exp_b.size()), 64'd1);
          else begin
            e = exp_b.pop_front();
            chk("b_data", b_odata, e);
          end
          chk("b_last", b_olast, (out_cnt_b == 63));
          if (out_cnt_b == 63) begin out_cnt_b = 0; lasts_b++; end
          else out_cnt_b++;
        end
        stall = b_ovalid && !b_iready;
        hold = b_odata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Streams smp[] into one instance with random gaps, checking each bank write
  // one cycle after its accept and queueing the expected output point.
  task automatic load_frame(input bit sel_b, input int gap_pct);
    int n, guard, ns, nb;
    logic acc, drive;
    logic [17:0] e;
    string p;
    p = sel_b ? "b" : "a";
    ns = sel_b ? 64 : 16;
    nb = sel_b ? 8 : 4;
    n = 0;
    guard = 0;
    while (n < ns && guard < 4000) begin
      guard++;
      drive = !(int'($urandom_range(99)) < gap_pct);
      if (sel_b) begin
        b_valid = drive; b_data = smp[n]; acc = drive && b_ready;
      end else begin
        a_valid = drive; a_data = smp[n]; acc = drive && a_ready;
      end
      @(negedge clk);
      if (acc) begin
        e = sel_b ? {4'b0000, smp[n]} : {{4{smp[n][13]}}, smp[n]};
        chk({p, "_we"}, sel_b ? b_we : {4'b0, a_we}, 64'(1) << (n % nb));
        chk({p, "_waddr"}, sel_b ? b_waddr : {1'b0, a_waddr}, n / nb);
        chk({p, "_wdata"}, sel_b ? b_cdata : a_cdata, e);
        if (sel_b) exp_b.push_back(e);
        else exp_a.push_back(e + ofs_a);
        n++;
      end else begin
        chk({p, "_we_gap"}, sel_b ? b_we : {4'b0, a_we}, 0);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk({p, "_load_count"}, n, ns);
  endtask

  task automatic wait_lasts(input bit sel_b, input int target, input int budget);
    int g = 0;
    while ((sel_b ? lasts_b : lasts_a) < target && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk(sel_b ? "b_frames_done" : "a_frames_done", sel_b ? lasts_b : lasts_a, target);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_start", a_start, 0);
    chk("rst_a_ovalid", a_ovalid, 0);
    chk("rst_a_state", a_state, ST_LOAD);
    chk("rst_b_ready", b_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_ready_after_rst", a_ready, 1);
    chk("b_ready_after_rst", b_ready, 1);

    // Frame 1: samples 0..15 back to back, core returns 100+index
    for (int i = 0; i < 16; i++) smp[i] = 14'(i);
    ofs_a = 18'd100;
    rmode = 1'b0;
    load_frame(1'b0, 0);
    chk("a_ready_drop", a_ready, 0);
    chk("a_start_early", a_start, 0);
    chk("a_busy_kick", a_busy, 1);
    @(negedge clk);
    chk("a_start_pulse", a_start, 1);
    @(negedge clk);
    chk("a_start_single", a_start, 0);
    guard = 0;
    while (a_state != ST_UNLOAD && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("a_unload_entry", a_state, ST_UNLOAD);
    chk("a_lat_cycle0", a_ovalid, 0);
    @(negedge clk);
    chk("a_lat_cycle1", a_ovalid, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("a_burst_valid", a_ovalid, 1);
    end
    @(negedge clk);
    chk("a_back_to_load", a_state, ST_LOAD);
    chk("a_ready_rise", a_ready, 1);
    chk("a_busy_idle", a_busy, 0);
    chk("a_frame1_lasts", lasts_a, 1);

    // Three frames with random gaps and random downstream stalls
    ofs_a = '0;
    rmode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) smp[i] = 14'($urandom_range(16383));
      if (f == 0) begin
        smp[0] = 14'h2000;
        smp[1] = 14'h1FFF;
      end
      load_frame(1'b0, 50);
      wait_lasts(1'b0, 2 + f, 3000);
    end
    chk("a_queue_empty", exp_a.size(), 0);
    chk("a_three_lasts", lasts_a, 4);

    // Reset in the middle of unload
    rmode = 1'b0;
    ofs_a = 18'd7;
    for (int i = 0; i < 16; i++) smp[i] = 14'($urandom_range(16383));
    load_frame(1'b0, 0);
    guard = 0;
    while (out_cnt_a < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("a_reached_5_out", out_cnt_a >= 5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", a_ovalid, 0);
    chk("mid_rst_olast", a_olast, 0);
    chk("mid_rst_odata", a_odata, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_raddr", a_raddr, 0);
    chk("mid_rst_state", a_state, ST_LOAD);
    exp_a.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_ready_after_mid_rst", a_ready, 1);
    for (int i = 0; i < 16; i++) smp[i] = 14'($urandom_range(16383));
    load_frame(1'b0, 0);
    wait_lasts(1'b0, 5, 500);
    chk("a_queue_empty_end", exp_a.size(), 0);

    // Eight banks, 64 points, zero extension, random gaps and stalls
    for (int i = 0; i < 64; i++) smp[i] = 14'(i);
    smp[5] = 14'h2000;
    rmode = 1'b1;
    load_frame(1'b1, 50);
    wait_lasts(1'b1, 1, 3000);
    chk("b_queue_empty", exp_b.size(), 0);
    @(negedge clk);
    chk("b_back_to_load", b_state, ST_LOAD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
